// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle multiply/divide sequencer that owns the HI/LO
// registers. It runs a 32-step shift-add multiply or restoring divide on
// operand magnitudes, fixes up the signs in a final FIX cycle and commits
// the result to HI/LO. While an operation is in flight it holds the
// pipeline through the combinational stall output.
//
// Handshake: an issue is accepted when start=1 and flush=0 in IDLE; stall is
// high from that cycle until the result commits, so the issuing instruction
// proceeds in the cycle where done pulses (stall=0). flush aborts at any time
// without writing HI/LO.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    input  logic             hi_wen,
    input  logic             lo_wen,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;      // op[1]=divide, op[0]=unsigned
    logic               sign_a;    // dividend/multiplicand sign (signed ops only)
    logic               sign_b;
    logic [WIDTH-1:0]   opnd;      // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0]   acc;       // product high half (mul) or remainder (div)
    logic [WIDTH-1:0]   mq;        // multiplier/product low half or quotient

    // Issue-side magnitudes: signed ops work on |x|, unsigned on the raw value.
    logic               signed_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // One multiply step: add the multiplicand when the multiplier LSB is set,
    // keeping the carry so the following right shift does not lose it.
    logic [WIDTH:0]     mul_sum;

    // One restoring-divide step on the left-shifted {rem,quo} pair.
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;

    // Sign-corrected results presented during FIX.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    // Operand magnitudes and sign bits captured at issue.
    always_comb begin
        signed_in = ~op[0];
        mag_a     = (signed_in && srcA[WIDTH-1]) ? -srcA : srcA;
        mag_b     = (signed_in && srcB[WIDTH-1]) ? -srcB : srcB;
    end

    // Datapath for a single RUN iteration and the FIX-cycle sign correction.
    always_comb begin
        mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
        rem_sh   = {acc, mq[WIDTH-1]};
        div_ge   = (rem_sh >= {1'b0, opnd});
        // The trial remainder is below the divisor, so the low WIDTH bits suffice.
        div_diff = rem_sh[WIDTH-1:0] - opnd;

        prod     = {acc, mq};
        prod_fix = (~op_q[0] && (sign_a ^ sign_b)) ? -prod : prod;
        quo_fix  = (~op_q[0] && (sign_a ^ sign_b)) ? -mq : mq;
        rem_fix  = (~op_q[0] && sign_a) ? -acc : acc;

        if (op_q[1]) begin
            res_hi = rem_fix;
            res_lo = quo_fix;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Pipeline hold: raised in the issue cycle and through RUN/FIX; flush or
    // reset drop it immediately.
    always_comb begin
        stall = 1'b0;
        if (!rst && !flush) begin
            case (state)
                ST_IDLE: stall = start;
                ST_RUN:  stall = 1'b1;
                ST_FIX:  stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    // Sequencer FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            op_q   <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            mq     <= '0;
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;

            // MTHI/MTLO land only while idle; a result committed later wins.
            if (state == ST_IDLE) begin
                if (hi_wen) hi <= wdata;
                if (lo_wen) lo <= wdata;
            end

            if (flush) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            op_q   <= op;
                            sign_a <= signed_in & srcA[WIDTH-1];
                            sign_b <= signed_in & srcB[WIDTH-1];
                            acc    <= '0;
                            cnt    <= '1;
                            busy   <= 1'b1;
                            if (op[1]) begin
                                opnd <= mag_b;
                                mq   <= mag_a;
                            end else begin
                                opnd <= mag_a;
                                mq   <= mag_b;
                            end
                            // Divide by zero skips the iterations and leaves HI/LO alone.
                            if (op[1] && (srcB == '0)) state <= ST_DONE;
                            else                       state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (op_q[1]) begin
                            acc <= div_ge ? div_diff : rem_sh[WIDTH-1:0];
                            mq  <= {mq[WIDTH-2:0], div_ge};
                        end else begin
                            acc <= mul_sum[WIDTH:1];
                            mq  <= {mul_sum[0], mq[WIDTH-1:1]};
                        end
                        cnt <= cnt - 1'b1;
                        if (cnt == '0) state <= ST_FIX;
                    end
                    ST_FIX: begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized issues,
// checked against an arithmetic reference model through an expected queue.
module tb_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        flush;
  logic        hi_wen;
  logic        lo_wen;
  logic [31:0] wdata;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  logic [63:0] exp_q[$];
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  muldiv_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .flush(flush), .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic, {hi,lo}
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: begin p = sa * sb; return p; end
      2'd1: begin up = {32'h0, a} * {32'h0, b}; return up; end
      2'd2: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: return {a % b, a / b};
    endcase
  endfunction

  // Issue one operation and follow it until stall drops.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    int n;
    int exp_n;
    if (o[1] && b == 32'h0) begin
      exp_n = 1;
    end else begin
      r = ref_result(o, a, b);
      exp_q.push_back(r);
      {hi_m, lo_m} = r;
      exp_n = 34;
    end
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
      start = 1'b0; srcA = $urandom; srcB = $urandom; op = 2'($urandom_range(0, 3));
      #1;
    end
    start = 1'b0;
    check("stall_cycles", 64'(n), 64'(exp_n));
    check("hi_after_op", 64'(hi), 64'(hi_m));
    check("lo_after_op", 64'(lo), 64'(lo_m));
  endtask

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    hi_wen = 1'b1; lo_wen = 1'b0; wdata = h;
    @(negedge clk);
    hi_wen = 1'b0; lo_wen = 1'b1; wdata = l;
    @(negedge clk);
    lo_wen = 1'b0;
    hi_m = h; lo_m = l;
    check("mthi", 64'(hi), 64'(h));
    check("mtlo", 64'(lo), 64'(l));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int n;
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; op = 2'd0; srcA = '0; srcB = '0;
    flush = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0; wdata = '0;
    hi_m = '0; lo_m = '0;

    // monitor: pops an expectation for every done pulse
    fork
      forever begin
        logic [63:0] e;
        @(negedge clk);
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(done), 64'(0));
          end else begin
            e = exp_q.pop_front();
            check("done_hi", 64'(hi), 64'(e[63:32]));
            check("done_lo", 64'(lo), 64'(e[31:0]));
          end
        end
      end
    join_none

    // reset state
    repeat (2) @(negedge clk);
    start = 1'b1;
    #1;
    check("reset_stall", 64'(stall), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // directed vectors
    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi", 64'(hi), 64'h00000000FFFFFFFE);
    check("multu_max_lo", 64'(lo), 64'h0000000000000001);
    run_op(2'd0, 32'hFFFFFFFD, 32'd7);
    check("mult_neg_lo", 64'(lo), 64'h00000000FFFFFFEB);
    run_op(2'd2, 32'hFFFFFFF9, 32'd2);
    check("div_neg_lo", 64'(lo), 64'h00000000FFFFFFFD);
    check("div_neg_hi", 64'(hi), 64'h00000000FFFFFFFF);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo", 64'(lo), 64'h0000000080000000);
    check("div_ovf_hi", 64'(hi), 64'h0);

    // divide by zero keeps preset HI/LO
    write_hilo(32'h11, 32'h22);
    run_op(2'd3, 32'h12345678, 32'h0);
    check("div0_hi", 64'(hi), 64'h11);
    check("div0_lo", 64'(lo), 64'h22);

    // flush in RUN cycle 10
    @(negedge clk);
    start = 1'b1; op = 2'd3; srcA = 32'd100; srcB = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush_stall", 64'(stall), 64'(0));
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_hi", 64'(hi), 64'(hi_m));
    check("flush_lo", 64'(lo), 64'(lo_m));
    run_op(2'd3, 32'd100, 32'd7);
    check("reissue_lo", 64'(lo), 64'd14);
    check("reissue_hi", 64'(hi), 64'd2);

    // start while busy is ignored
    exp_q.push_back(ref_result(2'd1, 32'd12345, 32'd678));
    {hi_m, lo_m} = ref_result(2'd1, 32'd12345, 32'd678);
    @(negedge clk);
    start = 1'b1; op = 2'd1; srcA = 32'd12345; srcB = 32'd678;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      op = 2'd2; srcA = $urandom; srcB = $urandom_range(1, 100);
    end
    start = 1'b0;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_start_hi", 64'(hi), 64'(hi_m));
    check("busy_start_lo", 64'(lo), 64'(lo_m));

    // reset in the middle of a MULT
    @(negedge clk);
    start = 1'b1; op = 2'd0; srcA = 32'd99; srcB = 32'd77;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_stall", 64'(stall), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_hi", 64'(hi), 64'(0));
    check("midrst_lo", 64'(lo), 64'(0));
    hi_m = '0; lo_m = '0;
    @(negedge clk);
    rst = 1'b0;

    // randomized issues
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom_range(0, 15);
        1: rb = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h80000000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      if ($urandom_range(0, 5) == 0) write_hilo($urandom, $urandom);
      run_op(ro, ra, rb);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle multiply/divide sequencer that sits beside the EXE-stage ALU and owns the architectural HI/LO registers.
- Accepts MULT/MULTU/DIV/DIVU issues from EXE and runs a 32-iteration radix-2 shift-add multiply or restoring divide.
- Holds the pipeline via `stall` until the result is committed to HI/LO.
- Also services MTHI/MTLO writes and supplies HI/LO to EXE for MFHI/MFLO.

Parameters:
- `WIDTH`, 32, operand and HI/LO width.
- `CNT_W`, 5, iteration counter width; log2(`WIDTH`).

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: issue strobe from EXE; sampled only in IDLE.
- `op` input 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `srcA` input `WIDTH`: multiplicand / dividend (rs).
- `srcB` input `WIDTH`: multiplier / divisor (rt).
- `flush` input 1: exception/flush from the pipeline; aborts any operation.
- `hi_wen` input 1: MTHI write strobe.
- `lo_wen` input 1: MTLO write strobe.
- `wdata` input `WIDTH`: MTHI/MTLO data.
- `stall` output 1: pipeline hold request, combinational.
- `busy` output 1: state != IDLE, registered.
- `done` output 1: one-cycle pulse when HI/LO are committed by an operation.
- `hi` output `WIDTH`: HI register.
- `lo` output `WIDTH`: LO register.

Behaviour:
- Reset (async, `rst`=1): state=IDLE, counter=0, `hi`=0, `lo`=0, `busy`=0, `done`=0, all internal operand/accumulator registers 0. `stall`=0 while in reset.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - `start`=1 and `flush`=0: latch `op`; latch |`srcA`| and |`srcB`| (magnitudes for signed ops, raw for unsigned); latch the sign bits; counter=31; go to RUN.
  - Exception: DIV/DIVU with `srcB`=0 goes directly to DONE with HI/LO unchanged and no `done` pulse.
  - `stall`=`start`&!`flush` in IDLE, so the issuing instruction holds in the same cycle.
- RUN: one iteration per cycle; `stall`=1.
  - Multiply: 64-bit {acc,mq}; if mq[0], acc += multiplicand (33-bit carry kept); then shift right by 1.
  - Divide: shift {rem,quo} left by 1; trial = rem − divisor; if trial ≥ 0, rem = trial and quo[0]=1.
  - counter decrements; when counter=0 at the edge, go to FIX. RUN lasts exactly 32 cycles.
- FIX: one cycle, `stall`=1.
  - Signed ops apply sign correction: product negated (64-bit) if the operand signs differ; quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - At the end of FIX write {`hi`,`lo`} = product, or `hi`=remainder and `lo`=quotient. Go to DONE.
- DONE: `done`=1 (only when entered from FIX), `stall`=0; next state IDLE unconditionally.
- Latency: from the `start` cycle to the new HI/LO being visible = 34 edges. `stall` is high for exactly 34 cycles (start cycle + 32 RUN + 1 FIX). The instruction proceeds in the DONE cycle.
- `flush`=1 in any state: next state IDLE; HI/LO not written by the aborted operation; `stall` goes low combinationally in that cycle; no `done` pulse.
- `start` while not IDLE: ignored.
- MTHI/MTLO:
  - In IDLE, `hi_wen`/`lo_wen` write `wdata` at the edge regardless of `start`. A result of a simultaneously started operation overwrites later.
  - Not IDLE: writes ignored (the pipeline is stalled, so none legally arrive).
- Overflow case: −2^31 / −1 (DIV) yields `lo`=0x80000000, `hi`=0 — no trap, per MIPS.
- Arithmetic is modulo 2^`WIDTH` per half; no overflow flag is produced.

Test Plan:
- MULTU `srcA`=0xFFFFFFFF, `srcB`=0xFFFFFFFF -> `stall` high 34 cycles, `done` pulse, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT `srcA`=0xFFFFFFFD (−3), `srcB`=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (−21).
- DIV `srcA`=0xFFFFFFF9 (−7), `srcB`=2 -> `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1). Then DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIVU any / 0 with `hi`=0x11, `lo`=0x22 preset via MTHI/MTLO -> no RUN cycles, `stall` only in the start cycle, `hi`/`lo` unchanged, no `done`.
- Start DIVU 100/7, assert `flush` at RUN cycle 10 -> `stall` low that cycle, IDLE next, `hi`/`lo` keep prior values. Re-issue -> `lo`=14, `hi`=2.
- Assert `rst` mid-RUN of a MULT -> immediate IDLE, `hi`=`lo`=0, `stall`=0. `start` asserted while busy is ignored (verify the result matches the first operation).
